bus_io_port: RTL and testbench

BUS_IO_PORT -- requirements
Module: bus_io_port

---
 rtl/bus_io_port.sv | 119 +++++++++++
 tb/tb_bus_io_port.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_io_port.sv
// CPU-bus I/O port: circular TX FIFO toward an external sink and a one-word RX holding register.
// Define IO_PORT_STATUS_EN to enable status-word reads through status_out.
module bus_io_port #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_in,
    input  logic        port_in,
    input  logic        port_out,
    input  logic        status_out,
    output logic [15:0] bus_out,
    output logic        bus_drive,
    output logic        wait_req,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = 5;

    typedef enum logic {RX_EMPTY = 1'b0, RX_FULL = 1'b1} rx_state_e;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   rx_hold_q;
    rx_state_e     rx_state_q, rx_state_d;

    logic full, push, pop, drop, rd_sel, status_sel, rx_full, capture;

    assign full     = (count_q == CW'(DEPTH));
    assign tx_valid = (count_q != '0);
    assign tx_data  = mem_q[rd_ptr_q];
    assign wait_req = full;

    // A pop frees the head slot in the same edge, so a full FIFO may still accept a push.
    assign pop    = tx_valid & tx_ready;
    assign push   = port_in & (~full | pop);
    assign drop   = port_in & full & ~pop;
    assign rd_sel = port_out & ~port_in;

`ifdef IO_PORT_STATUS_EN
    assign status_sel = status_out & ~port_in & ~port_out;
`else
    logic unused_status;
    assign status_sel    = 1'b0;
    assign unused_status = status_out ^ ovf_q;
`endif

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A drop in the same cycle as a status read must leave the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (status_sel) ovf_d = 1'b0;
        if (drop)       ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rx_hold_q <= '0;
        end else begin
            if (push)    wr_ptr_q  <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q  <= rd_ptr_q + PW'(1);
            if (capture) rx_hold_q <= rx_data;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wr_ptr_q] <= bus_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) rx_state_q <= RX_EMPTY;
        else      rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RX_EMPTY: if (rx_valid) rx_state_d = RX_FULL;
            RX_FULL:  if (rd_sel)   rx_state_d = RX_EMPTY;
            default:  rx_state_d = RX_EMPTY;
        endcase
    end

    always_comb begin
        rx_full   = (rx_state_q == RX_FULL);
        rx_ready  = (rx_state_q == RX_EMPTY);
        capture   = rx_ready & rx_valid;
        bus_drive = rd_sel | status_sel;
        bus_out   = 16'h0000;
        if (rd_sel) begin
            if (rx_full) bus_out = rx_hold_q;
        end else if (status_sel) begin
            bus_out = {ovf_q, rx_full, 9'b0, count_q};
        end
    end

endmodule

// File: tb/tb_bus_io_port.sv
// Bench for bus_io_port: TX scoreboard monitor, read-path vector table and directed corner sequences.
// Status-word checks are compiled in when IO_PORT_STATUS_EN is defined.
module tb_bus_io_port;

    localparam int DEPTH = 4;

    logic        clk, rst;
    logic [15:0] bus_in, bus_out, tx_data, rx_data;
    logic        port_in, port_out, status_out, bus_drive, wait_req;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;
    logic [15:0] q[$];

    typedef struct {
        logic        pin;
        logic        pout;
        logic        sout;
        logic        exp_drive;
        logic [15:0] exp_out;
    } vec_t;
    vec_t vecs[7];

    bus_io_port #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .port_in(port_in), .port_out(port_out),
        .status_out(status_out), .bus_out(bus_out), .bus_drive(bus_drive), .wait_req(wait_req),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        port_in = 1'b1;
        bus_in  = w;
        tick();
        port_in = 1'b0;
    endtask

    task automatic status_chk(input string nm, input logic [15:0] exp);
        status_out = 1'b1;
        #1;
`ifdef IO_PORT_STATUS_EN
        chk({nm, "_drive"}, bus_drive, 1'b1);
        chk(nm, bus_out, exp);
`else
        chk({nm, "_ignored"}, bus_drive, 1'b0);
`endif
        status_out = 1'b0;
    endtask

    task automatic drain(input string nm);
        tx_ready = 1'b1;
        repeat (DEPTH) tick();
        tx_ready = 1'b0;
        chk({nm, "_empty"}, tx_valid, 1'b0);
    endtask

    // Scoreboard: checks current TX state at the falling edge, then applies the coming edge.
    always @(negedge clk) begin
        bit pop_m, push_m;
        if (mon_en) begin
            chk("tx_valid", tx_valid, q.size() != 0);
            chk("wait_req", wait_req, q.size() == DEPTH);
            if (q.size() != 0) chk("tx_data", tx_data, q[0]);
        end
        pop_m  = (q.size() != 0) && tx_ready;
        push_m = port_in && ((q.size() < DEPTH) || pop_m);
        if (!rst) begin
            q.delete();
        end else begin
            if (pop_m)  void'(q.pop_front());
            if (push_m) q.push_back(bus_in);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
`ifdef IO_PORT_STATUS_EN
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h4000};
`else
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
`endif
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};

        rst = 1'b0; bus_in = '0; port_in = 0; port_out = 0; status_out = 0;
        tx_ready = 0; rx_data = '0; rx_valid = 0;
        tick();
        tick();
        mon_en = 1;
        rst = 1'b1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_wait_req", wait_req, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_bus_drive", bus_drive, 1'b0);
        chk("rst_bus_out", bus_out, 16'h0000);

        // Fill to full with the sink stalled, then drain in order.
        for (int i = 1; i <= 4; i++) push_word(16'h1111 * 16'(i));
        chk("fill_wait_req", wait_req, 1'b1);
        status_chk("fill_status", 16'h0004);
        drain("seq1");

        // Push and pop together at full.
        for (int i = 1; i <= 4; i++) push_word(16'hA000 + 16'(i));
        port_in = 1'b1; bus_in = 16'hDEAD; tx_ready = 1'b1;
        tick();
        port_in = 1'b0; tx_ready = 1'b0;
        chk("pp_full_wait_req", wait_req, 1'b1);
        status_chk("pp_full_status", 16'h0004);
        drain("seq2");

        // Overflow: push at full with no pop is dropped.
        for (int i = 1; i <= 4; i++) push_word(16'hB000 + 16'(i));
        push_word(16'hBAD0);
        chk("ovf_wait_req", wait_req, 1'b1);
        status_out = 1'b1;
        #1;
`ifdef IO_PORT_STATUS_EN
        chk("ovf_status_1", bus_out, 16'h8004);
        tick();
        chk("ovf_status_2", bus_out, 16'h0004);
`else
        chk("ovf_status_ignored", bus_drive, 1'b0);
        chk("ovf_status_out", bus_out, 16'h0000);
        tick();
`endif
        status_out = 1'b0;
        drain("seq3");

        // RX capture, hold against a second offer, consuming read, read when empty.
        rx_data = 16'hBEEF; rx_valid = 1'b1;
        tick();
        rx_data = 16'h1234;
        #1;
        chk("rx_full_ready", rx_ready, 1'b0);
        tick();
        rx_valid = 1'b0; port_out = 1'b1;
        #1;
        chk("rx_read_drive", bus_drive, 1'b1);
        chk("rx_read_data", bus_out, 16'hBEEF);
        tick();
        chk("rx_after_read_ready", rx_ready, 1'b1);
        chk("rx_second_read_drive", bus_drive, 1'b1);
        chk("rx_second_read_data", bus_out, 16'h0000);
        tick();
        port_out = 1'b0;
        chk("rx_empty_read_ready", rx_ready, 1'b1);

        // Read-path table in RX_FULL with an empty FIFO; strobes never span a rising edge.
        rx_data = 16'hBEEF; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            #1;
            port_in = vecs[i].pin; port_out = vecs[i].pout; status_out = vecs[i].sout;
            bus_in = 16'h5A5A;
            #1;
            chk($sformatf("vec%0d_drive", i), bus_drive, vecs[i].exp_drive);
            chk($sformatf("vec%0d_out", i), bus_out, vecs[i].exp_out);
            port_in = 1'b0; port_out = 1'b0; status_out = 1'b0;
        end

        // Write and read together: write wins, RX word kept.
        tick();
        port_in = 1'b1; port_out = 1'b1; bus_in = 16'h7777;
        #1;
        chk("wr_rd_drive", bus_drive, 1'b0);
        chk("wr_rd_out", bus_out, 16'h0000);
        tick();
        port_in = 1'b0; port_out = 1'b0;
        chk("wr_rd_rx_kept", rx_ready, 1'b0);
        port_out = 1'b1;
        #1;
        chk("wr_rd_hold_data", bus_out, 16'hBEEF);
        tick();
        port_out = 1'b0;

        // Reset with two words queued and RX full; push and capture in the reset cycle are ignored.
        push_word(16'h8888);
        rx_data = 16'hCAFE; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("pre_rst_rx_full", rx_ready, 1'b0);
        rst = 1'b0; port_in = 1'b1; bus_in = 16'h9999; rx_valid = 1'b1; rx_data = 16'h1357;
        tick();
        rst = 1'b1; port_in = 1'b0; rx_valid = 1'b0;
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_rx_ready", rx_ready, 1'b1);
        chk("mid_rst_wait_req", wait_req, 1'b0);
        status_chk("mid_rst_status", 16'h0000);
        port_out = 1'b1;
        #1;
        chk("mid_rst_read", bus_out, 16'h0000);
        port_out = 1'b0;
        tick();
        chk("post_rst_tx_valid", tx_valid, 1'b0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
